fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter: RESET_PC, default 32'h00010000, first fetch address after reset.
REQ-002 Parameter: DEPTH, default 2, instruction queue entries; legal range 2..4.
REQ-003 clk_i  input  1  single clock; all state updates on posedge.
REQ-004 reset_i  input  1  reset; synchronous and active-high.
REQ-005 redirect_i  input  1  flush queue and restart fetch at redirect_pc_i.
REQ-006 redirect_pc_i  input  32  new fetch address; bits [1:0] ignored and treated as 0.
REQ-007 mem_req_valid_o  output  1  read request valid.
REQ-008 mem_req_ready_i  input  1  memory accepts request.
REQ-009 mem_req_addr_o  output  32  word-aligned read address.
REQ-010 mem_resp_valid_i  input  1  read data valid; responses in request order, at least 1 cycle after acceptance.
REQ-011 mem_resp_data_i  input  32  read data.
REQ-012 instr_valid_o  output  1  queue head valid toward decode.
REQ-013 instr_ready_i  input  1  decode consumes head.
REQ-014 instr_o  output  32  head instruction word.
REQ-015 pc_o  output  32  address of instr_o.

Function
REQ-016 State: fetch_pc, resp_pc (32b each); queue of DEPTH {pc, instr} entries with count; outstanding and drop counters, each wide enough for DEPTH.
REQ-017 mem_req_valid_o = !redirect_i && (count + outstanding + drop < DEPTH); mem_req_addr_o = {fetch_pc[31:2], 2'b00}.
REQ-018 Request accepted on mem_req_valid_o && mem_req_ready_i: fetch_pc += 4 (mod 2^32), outstanding += 1.
REQ-019 mem_req_valid_o, once asserted, stays asserted with a stable address until accepted, unless redirect_i or reset_i.
REQ-020 Response with drop > 0: discarded, drop -= 1; no queue change.
REQ-021 Response with drop == 0: push {resp_pc, mem_resp_data_i} at tail, resp_pc += 4, outstanding -= 1.
REQ-022 instr_valid_o = (count > 0) && !redirect_i; instr_o/pc_o = head entry, combinational from registers.
REQ-023 Pop on instr_valid_o && instr_ready_i; simultaneous push and pop leaves count unchanged and preserves order.
REQ-024 Credit rule of REQ-017 guarantees no push into a full queue; no back-pressure on responses exists.
REQ-025 Fetch-to-decode latency: request accepted cycle N, response cycle N+k (k>=1), instr_valid_o from cycle N+k+1.
REQ-026 redirect_i (highest priority below reset): count := 0; fetch_pc := resp_pc := {redirect_pc_i[31:2],2'b00}; drop := drop + outstanding - (1 if a response arrives this cycle, else 0); outstanding := 0; no request issued, no pop, no push that cycle.
REQ-027 Back-to-back redirects: last one wins; drop accumulates until all stale responses are discarded.
REQ-028 fetch_pc wraps 32'hFFFFFFFC -> 32'h00000000 without special handling.

Reset
REQ-029 reset_i high at posedge: fetch_pc := resp_pc := RESET_PC; count, outstanding, drop := 0; queue contents don't-care.
REQ-030 While reset_i high: mem_req_valid_o = 0, instr_valid_o = 0; in-flight responses arriving during reset are ignored.
REQ-031 Memory interface is reset on the same reset_i, so no stale responses exist after reset release; first request issued in the first cycle with reset_i low.

Verification
REQ-032 Reset release, ready=1, 1-cycle memory returning addr^32'hA5A5A5A5: pc_o sequence 0x10000, 0x10004, 0x10008 with matching data, instr_valid_o first high 2 cycles after reset release.
REQ-033 instr_ready_i=0 for 10 cycles: exactly DEPTH requests issued, queue fills, mem_req_valid_o=0; raise ready -> entries drained in order, no loss/duplication.
REQ-034 Redirect to 0x2000 with 2 requests outstanding: the two late responses are discarded, next pc_o = 0x2000, drop returns to 0.
REQ-035 Redirect coincident with a response and an instr_ready_i pop: no push, no pop, instr_valid_o=0 that cycle, next pc_o = redirect target.
REQ-036 mem_req_ready_i held 0 for 5 cycles: mem_req_addr_o stable at 0x10000, valid stays high; accepted on ready; then redirect_pc_i = 0x3003 -> request address 0x3000.
REQ-037 Random ready/latency/redirect soak of 10k cycles against a reference PC model: every delivered {pc_o, instr_o} matches model; count never exceeds DEPTH.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues word-aligned reads, queues in-order responses
// for decode, and flushes/redirects with a drop counter for stale responses.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0001_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        mem_req_valid_o,
    input  logic        mem_req_ready_i,
    output logic [31:0] mem_req_addr_o,
    input  logic        mem_resp_valid_i,
    input  logic [31:0] mem_resp_data_i,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned SW = CW + 2;
    localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   resp_pc_q, resp_pc_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] outstanding_q, outstanding_d;
    logic [CW-1:0] drop_q, drop_d;
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [31:0]   q_pc_q    [DEPTH];
    logic [31:0]   q_instr_q [DEPTH];

    logic          req_fire;
    logic          push;
    logic          pop;
    logic [SW-1:0] credit_used;

    // Circular pointer advance that also works for non-power-of-two depths.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(DEPTH - 1)) begin
            return '0;
        end
        return p + PW'(1);
    endfunction

    // Handshake-facing outputs and credit accounting.
    always_comb begin
        credit_used     = SW'(count_q) + SW'(outstanding_q) + SW'(drop_q);
        mem_req_valid_o = !reset_i && !redirect_i && (credit_used < SW'(DEPTH));
        mem_req_addr_o  = fetch_pc_q & ALIGN_MASK;
        instr_valid_o   = !reset_i && !redirect_i && (count_q != '0);
        instr_o         = q_instr_q[head_q];
        pc_o            = q_pc_q[head_q];
        req_fire        = mem_req_valid_o && mem_req_ready_i;
        pop             = instr_valid_o && instr_ready_i;
        push            = mem_resp_valid_i && !redirect_i && (drop_q == '0);
    end

    // Next-state: redirect flushes everything, otherwise request/response/pop bookkeeping.
    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        resp_pc_d     = resp_pc_q;
        count_d       = count_q;
        outstanding_d = outstanding_q;
        drop_d        = drop_q;
        head_d        = head_q;
        tail_d        = tail_q;

        if (redirect_i) begin
            fetch_pc_d    = redirect_pc_i & ALIGN_MASK;
            resp_pc_d     = redirect_pc_i & ALIGN_MASK;
            count_d       = '0;
            head_d        = '0;
            tail_d        = '0;
            outstanding_d = '0;
            // A response landing this cycle retires one of the stale transactions.
            drop_d        = drop_q + outstanding_q - CW'(mem_resp_valid_i);
        end else begin
            if (req_fire) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            if (mem_resp_valid_i && (drop_q != '0)) begin
                drop_d = drop_q - CW'(1);
            end
            if (push) begin
                resp_pc_d = resp_pc_q + 32'd4;
                tail_d    = ptr_inc(tail_q);
            end
            if (pop) begin
                head_d = ptr_inc(head_q);
            end
            outstanding_d = outstanding_q + CW'(req_fire) - CW'(push);
            count_d       = count_q + CW'(push) - CW'(pop);
        end
    end

    // Control state register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            fetch_pc_q    <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            count_q       <= '0;
            outstanding_q <= '0;
            drop_q        <= '0;
            head_q        <= '0;
            tail_q        <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            resp_pc_q     <= resp_pc_d;
            count_q       <= count_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
            head_q        <= head_d;
            tail_q        <= tail_d;
        end
    end

    // Queue storage; contents are don't-care until a push makes them valid.
    always_ff @(posedge clk_i) begin
        if (push) begin
            q_pc_q[tail_q]    <= resp_pc_q;
            q_instr_q[tail_q] <= mem_resp_data_i;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: in-order memory model plus a
// PC-stream scoreboard, directed scenarios and a random soak.
module tb_fetch_unit;

    localparam int unsigned DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0001_0000;
    localparam logic [31:0] XORV     = 32'hA5A5_A5A5;
    localparam logic [31:0] MASK     = 32'hFFFF_FFFC;

    logic        clk = 1'b0;
    logic        reset_i = 1'b1;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = '0;
    logic        mem_req_valid_o;
    logic        mem_req_ready_i = 1'b1;
    logic [31:0] mem_req_addr_o;
    logic        mem_resp_valid_i = 1'b0;
    logic [31:0] mem_resp_data_i = '0;
    logic        instr_valid_o;
    logic        instr_ready_i = 1'b1;
    logic [31:0] instr_o;
    logic [31:0] pc_o;

    fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk_i           (clk),
        .reset_i         (reset_i),
        .redirect_i      (redirect_i),
        .redirect_pc_i   (redirect_pc_i),
        .mem_req_valid_o (mem_req_valid_o),
        .mem_req_ready_i (mem_req_ready_i),
        .mem_req_addr_o  (mem_req_addr_o),
        .mem_resp_valid_i(mem_resp_valid_i),
        .mem_resp_data_i (mem_resp_data_i),
        .instr_valid_o   (instr_valid_o),
        .instr_ready_i   (instr_ready_i),
        .instr_o         (instr_o),
        .pc_o            (pc_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
        bit          stale;
    } mreq_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    mreq_t       memq[$];
    ent_t        modq[$];
    logic [31:0] m_fetch_pc = RESET_PC;
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;
    int          kmin = 1;
    int          kmax = 1;
    int          deliveries = 0;

    logic        obs_req_valid, obs_accept, obs_ivalid, obs_pop;
    logic [31:0] obs_addr, obs_pc, obs_instr;

    // One clock: memory model drives response, outputs are sampled mid-cycle
    // and compared with the reference, then the reference advances.
    task automatic step();
        mreq_t r;
        bit    exp_req, exp_iv;
        int    due;
        if (reset_i) begin
            mem_resp_valid_i = 1'($urandom_range(1, 0));
            mem_resp_data_i  = $urandom;
        end else if (memq.size() > 0 && memq[0].due <= cyc) begin
            mem_resp_valid_i = 1'b1;
            mem_resp_data_i  = memq[0].addr ^ XORV;
        end else begin
            mem_resp_valid_i = 1'b0;
            mem_resp_data_i  = $urandom;
        end
        @(negedge clk);
        obs_req_valid = mem_req_valid_o;
        obs_addr      = mem_req_addr_o;
        obs_accept    = mem_req_valid_o && mem_req_ready_i;
        obs_ivalid    = instr_valid_o;
        obs_pc        = pc_o;
        obs_instr     = instr_o;
        obs_pop       = instr_valid_o && instr_ready_i;
        if (reset_i) begin
            total++;
            if (obs_req_valid !== 1'b0 || obs_ivalid !== 1'b0) begin
                bad++;
                $display("FAIL reset_outputs: got req=%b ivalid=%b expected 0/0", obs_req_valid, obs_ivalid);
            end
            memq.delete();
            modq.delete();
            m_fetch_pc = RESET_PC;
        end else begin
            exp_req = !redirect_i && (memq.size() + modq.size() < int'(DEPTH));
            exp_iv  = !redirect_i && (modq.size() > 0);
            total++;
            if (obs_req_valid !== exp_req) begin
                bad++;
                $display("FAIL req_valid cyc=%0d: got %b expected %b", cyc, obs_req_valid, exp_req);
            end
            if (exp_req) begin
                total++;
                if (obs_addr !== (m_fetch_pc & MASK)) begin
                    bad++;
                    $display("FAIL req_addr cyc=%0d: got %h expected %h", cyc, obs_addr, m_fetch_pc & MASK);
                end
            end
            total++;
            if (obs_ivalid !== exp_iv) begin
                bad++;
                $display("FAIL instr_valid cyc=%0d: got %b expected %b", cyc, obs_ivalid, exp_iv);
            end
            if (exp_iv && obs_ivalid) begin
                total++;
                if (obs_pc !== modq[0].pc || obs_instr !== modq[0].instr) begin
                    bad++;
                    $display("FAIL head cyc=%0d: got pc=%h instr=%h expected pc=%h instr=%h",
                             cyc, obs_pc, obs_instr, modq[0].pc, modq[0].instr);
                end
            end
            if (mem_resp_valid_i) begin
                r = memq.pop_front();
                if (!redirect_i && !r.stale) modq.push_back('{r.addr, mem_resp_data_i});
            end
            if (redirect_i) begin
                modq.delete();
                foreach (memq[i]) memq[i].stale = 1'b1;
                m_fetch_pc = redirect_pc_i & MASK;
            end else begin
                if (exp_iv && instr_ready_i) begin
                    void'(modq.pop_front());
                    deliveries++;
                end
                if (exp_req && mem_req_ready_i) begin
                    due = cyc + $urandom_range(kmax, kmin);
                    if (memq.size() > 0 && memq[$].due >= due) due = memq[$].due + 1;
                    memq.push_back('{m_fetch_pc & MASK, due, 1'b0});
                    m_fetch_pc = m_fetch_pc + 32'd4;
                end
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        reset_i    = 1'b1;
        redirect_i = 1'b0;
        step();
        step();
        reset_i = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        mem_req_ready_i = 1'b0;
        instr_ready_i   = 1'b1;
        step();
        total++;
        if (obs_req_valid !== 1'b1 || obs_addr !== RESET_PC) begin
            bad++;
            $display("FAIL first_req: got valid=%b addr=%h expected 1 %h", obs_req_valid, obs_addr, RESET_PC);
        end
        total++;
        if (obs_ivalid !== 1'b0) begin
            bad++;
            $display("FAIL reset_empty: got ivalid=%b expected 0", obs_ivalid);
        end
    endtask

    task automatic test_basic();
        int          c0, first_v, n;
        logic [31:0] pcs [3];
        kmin = 1; kmax = 1;
        mem_req_ready_i = 1'b1;
        instr_ready_i   = 1'b1;
        do_reset();
        c0 = cyc; first_v = -1; n = 0;
        for (int i = 0; i < 20 && n < 3; i++) begin
            step();
            if (obs_ivalid && first_v < 0) first_v = cyc - 1 - c0;
            if (obs_pop) begin
                pcs[n] = obs_pc;
                total++;
                if (obs_instr !== (obs_pc ^ XORV)) begin
                    bad++;
                    $display("FAIL basic_data: got %h expected %h", obs_instr, obs_pc ^ XORV);
                end
                n++;
            end
        end
        total++;
        if (first_v != 2) begin
            bad++;
            $display("FAIL basic_latency: got %0d expected 2", first_v);
        end
        total++;
        if (n != 3) begin
            bad++;
            $display("FAIL basic_count: got %0d expected 3", n);
        end else begin
            for (int i = 0; i < 3; i++) begin
                total++;
                if (pcs[i] !== RESET_PC + 32'(4 * i)) begin
                    bad++;
                    $display("FAIL basic_pc%0d: got %h expected %h", i, pcs[i], RESET_PC + 32'(4 * i));
                end
            end
        end
    endtask

    task automatic test_stall();
        int acc, n;
        kmin = 1; kmax = 1;
        mem_req_ready_i = 1'b1;
        do_reset();
        instr_ready_i = 1'b0;
        acc = 0;
        repeat (10) begin
            step();
            if (obs_accept) acc++;
        end
        total++;
        if (acc != int'(DEPTH)) begin
            bad++;
            $display("FAIL stall_reqs: got %0d expected %0d", acc, DEPTH);
        end
        total++;
        if (obs_req_valid !== 1'b0 || obs_ivalid !== 1'b1) begin
            bad++;
            $display("FAIL stall_full: got req=%b ivalid=%b expected 0/1", obs_req_valid, obs_ivalid);
        end
        instr_ready_i = 1'b1;
        n = 0;
        for (int i = 0; i < 20 && n < int'(DEPTH); i++) begin
            step();
            if (obs_pop) begin
                total++;
                if (obs_pc !== RESET_PC + 32'(4 * n)) begin
                    bad++;
                    $display("FAIL drain_pc%0d: got %h expected %h", n, obs_pc, RESET_PC + 32'(4 * n));
                end
                n++;
            end
        end
        total++;
        if (n != int'(DEPTH)) begin
            bad++;
            $display("FAIL drain_count: got %0d expected %0d", n, DEPTH);
        end
    endtask

    // Shared by redirect scenarios: wait for the first delivery and check it.
    task automatic expect_first_pop(input logic [31:0] tgt, input string name);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 30 && !got; i++) begin
            step();
            if (obs_pop) begin
                got = 1'b1;
                total++;
                if (obs_pc !== tgt || obs_instr !== (tgt ^ XORV)) begin
                    bad++;
                    $display("FAIL %s: got pc=%h instr=%h expected pc=%h instr=%h",
                             name, obs_pc, obs_instr, tgt, tgt ^ XORV);
                end
            end
        end
        if (!got) begin
            total++;
            bad++;
            $display("FAIL %s: got no delivery expected pc=%h", name, tgt);
        end
    endtask

    task automatic test_redirect();
        int acc;
        kmin = 3; kmax = 3;
        mem_req_ready_i = 1'b1;
        instr_ready_i   = 1'b1;
        do_reset();
        acc = 0;
        repeat (2) begin
            step();
            if (obs_accept) acc++;
        end
        total++;
        if (acc != 2) begin
            bad++;
            $display("FAIL redir_outstanding: got %0d expected 2", acc);
        end
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h0000_2000;
        step();
        redirect_i = 1'b0;
        expect_first_pop(32'h0000_2000, "redir_target");
    endtask

    task automatic test_collide();
        bit found;
        kmin = 1; kmax = 1;
        mem_req_ready_i = 1'b1;
        instr_ready_i   = 1'b1;
        do_reset();
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (memq.size() > 0 && memq[0].due <= cyc && modq.size() > 0) found = 1'b1;
            else step();
        end
        total++;
        if (!found) begin
            bad++;
            $display("FAIL collide_setup: got no resp+pop cycle expected one");
        end else begin
            redirect_i    = 1'b1;
            redirect_pc_i = 32'h0000_4000;
            step();
            redirect_i = 1'b0;
            total++;
            if (obs_ivalid !== 1'b0 || obs_req_valid !== 1'b0) begin
                bad++;
                $display("FAIL collide_quiet: got ivalid=%b req=%b expected 0/0", obs_ivalid, obs_req_valid);
            end
            expect_first_pop(32'h0000_4000, "collide_target");
        end
    endtask

    task automatic test_req_stall();
        kmin = 1; kmax = 1;
        instr_ready_i   = 1'b1;
        mem_req_ready_i = 1'b0;
        do_reset();
        repeat (5) begin
            step();
            total++;
            if (obs_req_valid !== 1'b1 || obs_addr !== RESET_PC) begin
                bad++;
                $display("FAIL hold_req: got valid=%b addr=%h expected 1 %h", obs_req_valid, obs_addr, RESET_PC);
            end
        end
        mem_req_ready_i = 1'b1;
        step();
        total++;
        if (obs_accept !== 1'b1) begin
            bad++;
            $display("FAIL hold_accept: got %b expected 1", obs_accept);
        end
        mem_req_ready_i = 1'b0;
        redirect_i      = 1'b1;
        redirect_pc_i   = 32'h0000_3003;
        step();
        redirect_i = 1'b0;
        step();
        total++;
        if (obs_req_valid !== 1'b1 || obs_addr !== 32'h0000_3000) begin
            bad++;
            $display("FAIL unaligned_redir: got valid=%b addr=%h expected 1 00003000", obs_req_valid, obs_addr);
        end
        mem_req_ready_i = 1'b1;
    endtask

    task automatic test_wrap();
        bit          saw;
        logic [31:0] prev;
        kmin = 1; kmax = 2;
        mem_req_ready_i = 1'b1;
        instr_ready_i   = 1'b1;
        do_reset();
        redirect_i    = 1'b1;
        redirect_pc_i = 32'hFFFF_FFF8;
        step();
        redirect_i = 1'b0;
        saw = 1'b0;
        prev = '0;
        for (int i = 0; i < 40 && !saw; i++) begin
            step();
            if (obs_pop) begin
                if (obs_pc == 32'h0 && prev == 32'hFFFF_FFFC) saw = 1'b1;
                prev = obs_pc;
            end
        end
        total++;
        if (!saw) begin
            bad++;
            $display("FAIL wrap: got last pc %h expected FFFFFFFC then 00000000", prev);
        end
    endtask

    task automatic test_soak();
        int d0;
        kmin = 1; kmax = 4;
        do_reset();
        d0 = deliveries;
        for (int i = 0; i < 10000; i++) begin
            mem_req_ready_i = ($urandom_range(99, 0) < 70);
            instr_ready_i   = ($urandom_range(99, 0) < 60);
            redirect_i      = ($urandom_range(99, 0) < 2);
            redirect_pc_i   = $urandom;
            step();
        end
        redirect_i = 1'b0;
        total++;
        if (deliveries - d0 < 500) begin
            bad++;
            $display("FAIL soak_progress: got %0d deliveries expected >= 500", deliveries - d0);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_redirect();
        test_collide();
        test_req_stall();
        test_wrap();
        test_soak();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
